// File: rtl/mag_peak_unit.sv
// Magnitude and windowed-peak unit: converts signed samples to unsigned magnitude
// with a one-deep valid/ready output stage, and reports the per-window maximum.
module mag_peak_unit #(
   parameter int WIDTH  = 16,
   parameter int WINDOW = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   in_data,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_mag,
   output logic             peak_valid,
   output logic [WIDTH-1:0] peak,
   output logic             sat_flag
);

   localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] run_max;
   logic [WIDTH-1:0] mag;
   logic [WIDTH-1:0] win_max;
   logic             is_sat;
   logic             accept;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // NOTE: every signal driven here gets a value before any branch, so no latch can form.
   always_comb begin
      is_sat = in_data[WIDTH] && (in_data[WIDTH-1:0] == '0);
      mag    = in_data[WIDTH-1:0];
      if (is_sat)
         mag = '1;
      else if (in_data[WIDTH])
         mag = (~in_data[WIDTH-1:0]) + WIDTH'(1);
      // Unsigned compare; a tie keeps the stored maximum.
      win_max = (mag > run_max) ? mag : run_max;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_valid <= 1'b0;
         out_mag   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_mag   <= mag;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt        <= '0;
         run_max    <= '0;
         peak       <= '0;
         peak_valid <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         if (accept) begin
            if (clear) begin
               // Restart: this sample opens the new window.
               cnt      <= CW'(1);
               run_max  <= mag;
               sat_flag <= is_sat;
            end else begin
               sat_flag <= sat_flag | is_sat;
               if (cnt == LAST) begin
                  peak       <= win_max;
                  peak_valid <= 1'b1;
                  cnt        <= '0;
                  run_max    <= '0;
               end else begin
                  cnt     <= cnt + CW'(1);
                  run_max <= win_max;
               end
            end
         end else if (clear) begin
            cnt      <= '0;
            run_max  <= '0;
            sat_flag <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mag_peak_unit.md
MAG_PEAK_UNIT -- requirements
Module: mag_peak_unit

Interface
REQ-001: Parameter WIDTH, default 16, magnitude width; input is WIDTH+1-bit two's complement.
REQ-002: Parameter WINDOW, default 8, accepted samples per peak window; legal range 2..256.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: n_rst  input  1  asynchronous, active-low reset.
REQ-005: in_valid  input  1  in_data holds a sample.
REQ-006: in_ready  output  1  unit can accept a sample this cycle.
REQ-007: in_data  input  WIDTH+1  signed two's-complement sample.
REQ-008: clear  input  1  synchronous window restart and sticky-flag clear.
REQ-009: out_valid  output  1  out_mag holds an unconsumed magnitude.
REQ-010: out_ready  input  1  downstream consumes out_mag this cycle.
REQ-011: out_mag  output  WIDTH  registered magnitude of the accepted sample.
REQ-012: peak_valid  output  1  one-cycle pulse; peak holds a completed window maximum.
REQ-013: peak  output  WIDTH  maximum magnitude of the last completed window.
REQ-014: sat_flag  output  1  sticky; a saturated sample has been accepted.

Function
REQ-015: Accept occurs on a cycle where in_valid=1 and in_ready=1; no other cycle changes datapath state.
REQ-016: in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-017: Magnitude: in_data[WIDTH]=0 -> in_data[WIDTH-1:0]; =1 -> (~in_data[WIDTH-1:0]) + 1, truncated to WIDTH bits.
REQ-018: Saturation: in_data = -2^WIDTH (MSB 1, all other bits 0) yields magnitude 2^WIDTH-1 (all ones) and sets sat_flag.
REQ-019: Latency 1: on an accept edge, out_mag loads the magnitude and out_valid=1 after that edge.
REQ-020: out_valid clears after an edge where out_ready=1 and no accept occurs; simultaneous consume and accept keeps out_valid=1 and loads the new value.
REQ-021: out_mag holds stable while out_valid=1 and out_ready=0.
REQ-022: Sample counter cnt counts accepts 0..WINDOW-1; running maximum run_max tracks the largest magnitude in the window.
REQ-023: On accept with cnt<WINDOW-1: cnt+1; run_max = max(run_max, mag).
REQ-024: On accept with cnt=WINDOW-1: peak loads max(run_max, mag); peak_valid=1 for exactly the next cycle; cnt wraps to 0; run_max=0.
REQ-025: peak holds its value between completions; peak_valid ignores out_ready and has no backpressure.
REQ-026: clear without accept: cnt=0, run_max=0, sat_flag=0; peak, out_mag and out_valid unchanged.
REQ-027: clear with accept: sample counted as first of the new window (cnt=1, run_max=mag); sat_flag = saturation of that sample; no peak_valid pulse; out path behaves per REQ-019.
REQ-028: clear does not suppress a peak_valid pulse already issued from the previous edge.
REQ-029: Equal magnitudes: max comparison is unsigned; ties leave run_max unchanged.

Reset
REQ-030: n_rst=0 SHALL immediately force out_valid=0, peak_valid=0, out_mag=0, peak=0, sat_flag=0, cnt=0, run_max=0.
REQ-031: in_ready SHALL read 1 during and after reset (out_valid=0).
REQ-032: Reset mid-window SHALL discard partial window and pending out_mag; the first accept after release starts a new window.

Verification (WIDTH=16, WINDOW=4)
REQ-033: Accept 17'h1FFFF, 17'h00005, 17'h10000 with out_ready=1 -> out_mag 1, 5, 16'hFFFF on successive cycles; sat_flag=1 after third.
REQ-034: Accept magnitudes 3, 9, 2, 7 -> single peak_valid pulse with peak=9 one cycle after the fourth accept; cnt back to 0.
REQ-035: out_ready=0 for 5 cycles after one accept -> out_valid=1, out_mag stable, in_ready=0, later samples not accepted, cnt not advanced.
REQ-036: Accept 100, 200, then clear+accept 50, then 10, 20, 30 -> peak=50; no pulse at clear.
REQ-037: Assert n_rst=0 asynchronously between edges after 2 accepts -> all outputs 0 immediately; next 4 accepts of 1, 2, 3, 4 -> peak=4.
REQ-038: Back-to-back accepts every cycle with out_ready=1 -> full throughput, out_valid continuously 1, no sample lost (count out_mag beats = accepts).
